// File: rtl/idft_pkg.sv
// IDFT shared types: frame geometry, capture FSM states, sample word.
// Imported by the frame capture stage and its buffer banks.
package idft_pkg;

  localparam int DW   = 64;
  localparam int NPTS = 32;
  localparam int AW   = 5;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DISCARD
  } cap_state_t;

  typedef struct packed {
    logic [31:0] im;
    logic [31:0] re;
  } sample_t;

endpackage

// File: rtl/idft_frame_capture_if.sv
// Host read port of the frame capture stage: rd_addr/frame_ack from
// the host (master), rd_data/frame_ready from the capture block (slave).
interface idft_frame_capture_if;
  import idft_pkg::*;

  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          frame_ready;
  logic          frame_ack;

  modport master (
    output rd_addr,
    output frame_ack,
    input  rd_data,
    input  frame_ready
  );

  modport slave (
    input  rd_addr,
    input  frame_ack,
    output rd_data,
    output frame_ready
  );

endinterface

// File: rtl/idft_frame_bank.sv
// One NPTS x DW frame buffer: single synchronous write port, async read.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module idft_frame_bank
  import idft_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sample_t       wdata,
  input  logic [AW-1:0] raddr,
  output sample_t       rdata
);

  sample_t mem [NPTS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/idft_frame_capture.sv
// Ping-pong capture of IDFT output frames; host reads ready frame via rd.
// Ports: wb_clk_i/wb_rst_i, next_out/data_in, rd (if), irq/status/frame_cnt.
module idft_frame_capture
  import idft_pkg::*;
(
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 next_out,
  input  logic [DW-1:0]        data_in,
  idft_frame_capture_if.slave  rd,
  output logic                 irq_o,
  output logic                 busy,
  output logic                 overflow,
  output logic                 restart_err,
  input  logic                 clr_flags,
  output logic [15:0]          frame_cnt
);

  cap_state_t    state, state_n;
  logic [AW-1:0] widx, widx_n;
  logic          next_out_r;
  logic          wr_bank, wr_bank_n;
  logic          rd_bank;
  logic [1:0]    full, full_n;
  logic [1:0]    set_mask, clr_mask;
  logic          edge_det;
  logic          last;
  logic          complete;
  logic          ack_ok;
  logic          we;
  logic          ovf_set;
  logic          rst_set;
  sample_t       word_in;
  sample_t       q0, q1;

  assign word_in  = data_in;
  assign edge_det = next_out & ~next_out_r;
  assign last     = (widx == AW'(NPTS - 1));
  assign complete = (state == CAPTURE) & last;
  assign ack_ok   = rd.frame_ack & full[rd_bank];

  // Bank bookkeeping after this cycle; a new edge is judged against it.
  assign set_mask  = {complete & wr_bank, complete & ~wr_bank};
  assign clr_mask  = {ack_ok & rd_bank, ack_ok & ~rd_bank};
  assign full_n    = (full & ~clr_mask) | set_mask;
  assign wr_bank_n = wr_bank ^ complete;

  always_comb begin
    state_n = state;
    widx_n  = widx;
    we      = 1'b0;
    ovf_set = 1'b0;
    rst_set = 1'b0;
    unique case (state)
      IDLE: ;
      CAPTURE: begin
        we     = 1'b1;
        widx_n = widx + AW'(1);
        if (last) state_n = IDLE;
      end
      DISCARD: begin
        widx_n = widx + AW'(1);
        if (last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (edge_det) begin
      widx_n = '0;
      if (state == CAPTURE && !last) begin
        // Abort: same bank restarts, the edge-cycle word is not kept.
        we      = 1'b0;
        rst_set = 1'b1;
        state_n = CAPTURE;
      end else if (!full_n[wr_bank_n]) begin
        state_n = CAPTURE;
      end else begin
        state_n = DISCARD;
        ovf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state       <= IDLE;
      widx        <= '0;
      next_out_r  <= 1'b0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= '0;
      frame_cnt   <= '0;
      overflow    <= 1'b0;
      restart_err <= 1'b0;
    end else begin
      state       <= state_n;
      widx        <= widx_n;
      next_out_r  <= next_out;
      wr_bank     <= wr_bank_n;
      rd_bank     <= rd_bank ^ ack_ok;
      full        <= full_n;
      if (complete) frame_cnt <= frame_cnt + 16'd1;
      overflow    <= ovf_set | (overflow & ~clr_flags);
      restart_err <= rst_set | (restart_err & ~clr_flags);
    end
  end

  idft_frame_bank u_bank0 (
    .clk   (wb_clk_i),
    .we    (we & ~wr_bank),
    .waddr (widx),
    .wdata (word_in),
    .raddr (rd.rd_addr),
    .rdata (q0)
  );

  idft_frame_bank u_bank1 (
    .clk   (wb_clk_i),
    .we    (we & wr_bank),
    .waddr (widx),
    .wdata (word_in),
    .raddr (rd.rd_addr),
    .rdata (q1)
  );

  // Read data is forced to zero while no frame is ready, so the
  // uninitialised buffers never leak out after reset.
  assign rd.frame_ready = full[rd_bank];
  assign rd.rd_data     = rd.frame_ready ? (rd_bank ? q1 : q0) : '0;
  assign irq_o          = full[rd_bank];
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_idft_frame_capture.sv
// Scoreboard bench for idft_frame_capture: directed frames, queued
// expectations, negedge monitor compares.
module tb_idft_frame_capture;
  import idft_pkg::*;

  logic          clk = 1'b0;
  logic          wb_rst_i;
  logic          next_out;
  logic [DW-1:0] data_in;
  logic          clr_flags;
  logic          irq_o;
  logic          busy;
  logic          overflow;
  logic          restart_err;
  logic [15:0]   frame_cnt;

  idft_frame_capture_if rif ();

  idft_frame_capture dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst_i),
    .next_out    (next_out),
    .data_in     (data_in),
    .rd          (rif),
    .irq_o       (irq_o),
    .busy        (busy),
    .overflow    (overflow),
    .restart_err (restart_err),
    .clr_flags   (clr_flags),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  localparam int S_DATA = 0;
  localparam int S_RDY  = 1;
  localparam int S_CNT  = 2;
  localparam int S_OVF  = 3;
  localparam int S_RST  = 4;
  localparam int S_BUSY = 5;
  localparam int S_IRQ  = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [63:0] obs(int sel);
    case (sel)
      S_DATA:  return rif.rd_data;
      S_RDY:   return {63'b0, rif.frame_ready};
      S_CNT:   return {48'b0, frame_cnt};
      S_OVF:   return {63'b0, overflow};
      S_RST:   return {63'b0, restart_err};
      S_BUSY:  return {63'b0, busy};
      default: return {63'b0, irq_o};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (q.size() != 0) begin
      e = q.pop_front();
      n_chk++;
      if (obs(e.sel) !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.sel), e.exp);
      end
    end
    if (dut.complete && dut.ack_ok) begin
      n_chk++;
      if (dut.wr_bank == dut.rd_bank) begin
        n_fail++;
        $display("FAIL same_bank: completion and ack both on bank %0d",
                 dut.wr_bank);
      end
    end
  end

  task automatic chk(string nm, int sel, logic [63:0] e);
    q.push_back('{nm, sel, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rdchk(string nm, logic [AW-1:0] a, logic [63:0] e);
    rif.rd_addr = a;
    chk(nm, S_DATA, e);
    tick();
  endtask

  task automatic strobe();
    next_out = 1'b1;
    tick();
    next_out = 1'b0;
  endtask

  task automatic send(logic [63:0] base, int n, bit edge_last, bit ack_last);
    for (int k = 0; k < n; k++) begin
      data_in       = base + 64'(k);
      next_out      = edge_last && (k == n - 1);
      rif.frame_ack = ack_last && (k == n - 1);
      tick();
    end
    next_out      = 1'b0;
    rif.frame_ack = 1'b0;
  endtask

  task automatic ack();
    rif.frame_ack = 1'b1;
    tick();
    rif.frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    wb_rst_i      = 1'b0;
    next_out      = 1'b0;
    clr_flags     = 1'b0;
    data_in       = '0;
    rif.frame_ack = 1'b0;
    rif.rd_addr   = '0;
    repeat (2) tick();
    wb_rst_i = 1'b1;
    tick();
  endtask

  localparam logic [63:0] T1 = 64'h0000_0001_0000_0000;
  localparam logic [63:0] FA = 64'h0000_0002_0000_0000;
  localparam logic [63:0] FB = 64'h0000_0003_0000_0000;
  localparam logic [63:0] FC = 64'h0000_0004_0000_0000;
  localparam logic [63:0] D1 = 64'h0000_0005_0000_0000;
  localparam logic [63:0] D2 = 64'h0000_0006_0000_0000;
  localparam logic [63:0] E0 = 64'h0000_0007_0000_0000;
  localparam logic [63:0] E1 = 64'h0000_0008_0000_0000;
  localparam logic [63:0] FF = 64'h0000_0009_0000_0000;
  localparam logic [63:0] FG = 64'h0000_000a_0000_0000;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wb_rst_i      = 1'b0;
    next_out      = 1'b0;
    clr_flags     = 1'b0;
    data_in       = '0;
    rif.frame_ack = 1'b0;
    rif.rd_addr   = '0;
    tick();
    chk("rst_ready", S_RDY, 0);
    chk("rst_irq", S_IRQ, 0);
    chk("rst_busy", S_BUSY, 0);
    chk("rst_cnt", S_CNT, 0);
    chk("rst_ovf", S_OVF, 0);
    chk("rst_rerr", S_RST, 0);
    chk("rst_data", S_DATA, 0);
    tick();
    wb_rst_i = 1'b1;
    tick();

    // 1: single frame, ready 33 cycles after the edge
    strobe();
    chk("t1_busy", S_BUSY, 1);
    send(T1, 31, 0, 0);
    chk("t1_ready_c32", S_RDY, 0);
    send(T1 + 64'd31, 1, 0, 0);
    chk("t1_ready_c33", S_RDY, 1);
    chk("t1_irq", S_IRQ, 1);
    chk("t1_cnt", S_CNT, 1);
    chk("t1_busy_done", S_BUSY, 0);
    rdchk("t1_rd5", 5, T1 + 64'd5);
    rdchk("t1_rd0", 0, T1);
    ack();
    chk("t1_ack_ready", S_RDY, 0);
    tick();

    // 2: back-to-back frames, edge on the final word of the first
    do_reset();
    strobe();
    send(FA, 32, 1, 0);
    send(FB, 32, 0, 0);
    chk("t2_ready", S_RDY, 1);
    chk("t2_cnt", S_CNT, 2);
    chk("t2_busy", S_BUSY, 0);
    rdchk("t2_rdA7", 7, FA + 64'd7);

    // 3: third frame with both banks full is discarded
    strobe();
    chk("t3_ovf", S_OVF, 1);
    chk("t3_busy", S_BUSY, 1);
    send(FC, 31, 0, 0);
    chk("t3_busy_31", S_BUSY, 1);
    send(FC + 64'd31, 1, 0, 0);
    chk("t3_busy_32", S_BUSY, 0);
    chk("t3_cnt", S_CNT, 2);
    rdchk("t3_rdA7", 7, FA + 64'd7);
    rdchk("t3_rdA20", 20, FA + 64'd20);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("t3_ovf_clr", S_OVF, 0);
    tick();
    ack();
    chk("t2_ready_ack1", S_RDY, 1);
    rdchk("t2_rdB7", 7, FB + 64'd7);
    rdchk("t3_rdB20", 20, FB + 64'd20);
    ack();
    chk("t2_ready_ack2", S_RDY, 0);
    tick();

    // 4: restart edge at word 10
    strobe();
    send(D1, 10, 0, 0);
    chk("t4_rerr_pre", S_RST, 0);
    strobe();
    chk("t4_rerr", S_RST, 1);
    chk("t4_busy", S_BUSY, 1);
    send(D2, 31, 0, 0);
    chk("t4_ready_pre", S_RDY, 0);
    chk("t4_cnt_pre", S_CNT, 2);
    send(D2 + 64'd31, 1, 0, 0);
    chk("t4_ready", S_RDY, 1);
    chk("t4_cnt", S_CNT, 3);
    rdchk("t4_rd0", 0, D2);
    rdchk("t4_rd20", 20, D2 + 64'd20);
    ack();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("t4_rerr_clr", S_RST, 0);
    tick();

    // 5: async reset at word 20
    strobe();
    send(E1, 20, 0, 0);
    wb_rst_i = 1'b0;
    #1;
    chk("t5_busy", S_BUSY, 0);
    chk("t5_cnt", S_CNT, 0);
    chk("t5_ready", S_RDY, 0);
    chk("t5_irq", S_IRQ, 0);
    chk("t5_data", S_DATA, 0);
    @(negedge clk);
    #1;
    wb_rst_i = 1'b1;
    tick();
    strobe();
    send(E0, 32, 0, 0);
    chk("t5_ready_new", S_RDY, 1);
    chk("t5_cnt_new", S_CNT, 1);
    rdchk("t5_rd31", 31, E0 + 64'd31);
    rdchk("t5_rd0", 0, E0);

    // 6: stray ack, then ack coinciding with completion
    ack();
    chk("t6_ready_ack", S_RDY, 0);
    ack();
    chk("t6_ready_stray", S_RDY, 0);
    strobe();
    send(FF, 32, 0, 0);
    chk("t6_readyF", S_RDY, 1);
    chk("t6_cntF", S_CNT, 2);
    rdchk("t6_rdF3", 3, FF + 64'd3);
    strobe();
    send(FG, 31, 0, 0);
    chk("t6_ready_pre", S_RDY, 1);
    chk("t6_rdF3_pre", S_DATA, FF + 64'd3);
    send(FG + 64'd31, 1, 0, 1);
    chk("t6_ready_co", S_RDY, 1);
    chk("t6_cntG", S_CNT, 3);
    rdchk("t6_rdG3", 3, FG + 64'd3);
    ack();
    chk("t6_ready_end", S_RDY, 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/idft_frame_capture.md
Name: idft_frame_capture

Overview:
Downstream stage of the IDFT core wrapper. It consumes the core's streamed output frame (a next_out strobe followed by 32 consecutive 64-bit words) into a ping-pong pair of 32x64 frame buffers. Completed frames are exposed to the Wishbone register file through a random-access read port with a ready/ack handshake and an interrupt. This removes the single-buffer overwrite hazard: the core can emit frame N+1 while the host drains frame N.

Parameters:
DW, 64, sample word width (imag:real packed, 32 bits each)
NPTS, 32, words per frame
AW, 5, address width (log2 NPTS)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  asynchronous, active-low reset
next_out  in  1  core output-frame strobe; rising edge marks frame start
data_in  in  DW  core output word
rd_addr  in  AW  host read index into the ready frame
rd_data  out  DW  word rd_addr of the ready bank (combinational)
frame_ready  out  1  a completed frame is readable
frame_ack  in  1  single-cycle pulse; host releases the ready frame
irq_o  out  1  interrupt, equals frame_ready
busy  out  1  state != IDLE
overflow  out  1  sticky: a frame was discarded because both banks were full
restart_err  out  1  sticky: next_out edge arrived mid-capture
clr_flags  in  1  synchronous clear of overflow and restart_err
frame_cnt  out  16  count of completed captured frames, wraps at 0xFFFF->0

Behaviour:
- Reset (wb_rst_i=0, async):
  - State is IDLE; wr_bank=0, rd_bank=0, full[1:0]=0, widx=0, next_out_r=0.
  - All outputs are 0.
  - Buffer contents are not reset.
- Edge detect: edge = next_out & ~next_out_r, where next_out_r is registered every cycle.
- Edge cycle E: data_in is sampled on cycles E+1 through E+NPTS, stored at indices 0 through NPTS-1.
- FSM:
  - IDLE, on edge: if full[wr_bank]=0, go to CAPTURE with widx=0; otherwise go to DISCARD and set overflow.
  - CAPTURE: write buf[wr_bank][widx] <= data_in and increment widx. On the write of widx=NPTS-1:
    - set full[wr_bank];
    - toggle wr_bank;
    - increment frame_cnt;
    - return to IDLE.
  - DISCARD: count NPTS cycles without writing, then return to IDLE.
  - Edge while in CAPTURE: abort the frame (bank not marked full), set restart_err, restart at widx=0. The same bank is reused.
  - Edge while in DISCARD: re-evaluate as in IDLE (capture if a bank has freed, otherwise restart the discard).
  - Edge on the same cycle as the final word: the final word is written and the frame completes. The edge is then evaluated as in IDLE against the updated state.
- Read side:
  - frame_ready = full[rd_bank], so it rises the cycle after the last word is sampled.
  - rd_data = buf[rd_bank][rd_addr].
  - frame_ack while frame_ready: clear full[rd_bank] and toggle rd_bank.
  - frame_ack while not ready is ignored.
  - Completion and ack on the same cycle both take effect (they always target different bits, or the same bit via set-then-clear). Set has priority only if the same bank is targeted, which cannot occur with ping-pong ordering; this is asserted in the bench.
- clr_flags: clears overflow and restart_err. A new set event on the same cycle wins.
- Throughput: back-to-back frames with 0 gap cycles are supported while a free bank exists.

Decomposition:
- Shared package idft_pkg holds:
  - NPTS and DW constants;
  - the capture FSM state enum {IDLE, CAPTURE, DISCARD};
  - the sample type (packed real/imag 32-bit pair), shared with the input-loading stage.
- One sub-module: idft_frame_bank, a 32xDW single-write-port, asynchronous-read memory, instantiated twice.

Test Plan:
1. Reset release, next_out rises, data_in=0x0000000100000000+k for k=0..31. Required response:
   - frame_ready=1 exactly 33 cycles after the edge;
   - rd_addr=5 returns 0x0000000100000005;
   - frame_cnt=1; irq_o=1.
2. Two back-to-back frames with no ack. Required response:
   - both banks become full and frame_cnt=2;
   - the first ack shows frame 1 data, then frame_ready stays 1 with frame 2 data;
   - the second ack drops frame_ready to 0.
3. Third frame while both banks are full. Required response:
   - overflow=1, busy for 32 cycles, no write;
   - frame_cnt stays 2 and bank data is unchanged;
   - clr_flags returns overflow to 0.
4. Edge at word 10 of a capture. Required response:
   - restart_err=1;
   - the restarted frame completes 32 words after the second edge;
   - frame_cnt increments once.
5. Async reset asserted mid-capture at word 20. Required response:
   - all outputs 0 immediately;
   - after release, a fresh frame captures into bank 0 correctly.
6. frame_ack pulsed with frame_ready=0, and an ack coinciding with completion of the other bank. Required response:
   - the stray ack is ignored;
   - with the coinciding ack, frame_ready stays 1 and now shows the new frame.
